// File: rtl/sig_rx.sv
// sig_rx: framed serial receiver for the sig_gen transmitter.
// Captures MESSAGE_WIDTH bits MSB-first while status_in is high. Each bit is
// sampled at the middle of its CYCLES_PER_BIT-long period. The received word is
// presented with a one-cycle valid strobe. A frame that ends before its last
// sample produces a one-cycle error strobe instead.
module sig_rx #(
    parameter int MESSAGE_WIDTH  = 16,
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     data_in,
    input  logic                     status_in,
    output logic [MESSAGE_WIDTH-1:0] msg_out,
    output logic                     msg_valid_out,
    output logic                     error_out,
    output logic                     busy_out
);

    localparam int BW = $clog2(MESSAGE_WIDTH + 1);
    localparam int CW = $clog2(CYCLES_PER_BIT + 1);

    // Position inside a bit period at which data_in is taken (mid-bit).
    localparam logic [CW-1:0] MID_CYC  = CW'((CYCLES_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CYC = CW'(CYCLES_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(MESSAGE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVE   = 2'd1,
        WAIT_IDLE = 2'd2
    } state_t;

    state_t                   state_reg;
    logic [MESSAGE_WIDTH-1:0] shift_reg;
    logic [BW-1:0]            bit_reg;
    logic [CW-1:0]            cyc_reg;

    logic [CW-1:0]            cur_cyc;
    logic [BW-1:0]            cur_bit;
    logic [MESSAGE_WIDTH-1:0] shift_base;
    logic [MESSAGE_WIDTH-1:0] shift_next;
    logic                     sample_now;
    logic                     last_sample;

    // Frame position seen by the current edge. The edge that detects the frame
    // in IDLE is position 0 of bit 0, so that edge can already take a sample.
    always_comb begin
        cur_cyc     = '0;
        cur_bit     = '0;
        shift_base  = '0;
        if (state_reg == RECEIVE) begin
            cur_cyc    = cyc_reg;
            cur_bit    = bit_reg;
            shift_base = shift_reg;
        end
        sample_now  = (cur_cyc == MID_CYC);
        shift_next  = sample_now ? ((shift_base << 1) | MESSAGE_WIDTH'(data_in))
                                 : shift_base;
        last_sample = sample_now && (cur_bit == LAST_BIT);
    end

    // Frame FSM: counters, shift register and registered output strobes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_reg       <= '0;
            cyc_reg       <= '0;
            msg_out       <= '0;
            msg_valid_out <= 1'b0;
            error_out     <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            msg_valid_out <= 1'b0;
            error_out     <= 1'b0;
            case (state_reg)
                IDLE, RECEIVE: begin
                    if (!status_in) begin
                        // A frame that drops before its last sample is discarded.
                        error_out <= (state_reg == RECEIVE);
                        state_reg <= IDLE;
                        busy_out  <= 1'b0;
                        shift_reg <= '0;
                        bit_reg   <= '0;
                        cyc_reg   <= '0;
                    end else begin
                        busy_out  <= 1'b1;
                        shift_reg <= shift_next;
                        if (last_sample) begin
                            msg_out       <= shift_next;
                            msg_valid_out <= 1'b1;
                            state_reg     <= WAIT_IDLE;
                            bit_reg       <= '0;
                            cyc_reg       <= '0;
                        end else begin
                            state_reg <= RECEIVE;
                            if (cur_cyc == LAST_CYC) begin
                                cyc_reg <= '0;
                                bit_reg <= cur_bit + BW'(1);
                            end else begin
                                cyc_reg <= cur_cyc + CW'(1);
                                bit_reg <= cur_bit;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    // Trailing bit time and over-long frames are ignored.
                    if (!status_in) begin
                        state_reg <= IDLE;
                        busy_out  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_rx.sv
// tb_sig_rx: drives three sig_rx instances (16b/1cpb, 16b/4cpb, 1b/1cpb) with
// directed and random frames. Expected outputs come from a frame-level model:
// a frame of L high cycles starting at E0 yields a valid pulse after edge
// E0+S (S = last-sample offset) when L > S, otherwise an error after E0+L;
// busy is high after edges E0..E0+L-1.
module tb_sig_rx;

    localparam int W_OF[3]   = '{16, 16, 1};
    localparam int CPB_OF[3] = '{1, 4, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st0, st1, st2, d0, d1, d2;
    logic [15:0] msg0, msg1;
    logic [0:0]  msg2;
    logic        v0, v1, v2, e0, e1, e2, b0, b1, b2;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;
    bit check_en = 0;

    // Model state
    logic [15:0] held_msg[3];
    logic [15:0] e_msg[3];
    logic        e_valid[3], e_err[3], e_busy[3];
    int          e0_edge[3], valid_edge[3], valid_cnt[3], err_cnt[3];

    logic [15:0] a_msg[3];
    logic        a_valid[3], a_err[3], a_busy[3];

    assign a_msg[0] = msg0;
    assign a_msg[1] = msg1;
    assign a_msg[2] = {15'b0, msg2};
    assign a_valid[0] = v0;
    assign a_valid[1] = v1;
    assign a_valid[2] = v2;
    assign a_err[0] = e0;
    assign a_err[1] = e1;
    assign a_err[2] = e2;
    assign a_busy[0] = b0;
    assign a_busy[1] = b1;
    assign a_busy[2] = b2;

    sig_rx #(.MESSAGE_WIDTH(16), .CYCLES_PER_BIT(1)) dut0 (
        .clk_in(clk), .rst_in(rst_n), .data_in(d0), .status_in(st0),
        .msg_out(msg0), .msg_valid_out(v0), .error_out(e0), .busy_out(b0));
    sig_rx #(.MESSAGE_WIDTH(16), .CYCLES_PER_BIT(4)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .data_in(d1), .status_in(st1),
        .msg_out(msg1), .msg_valid_out(v1), .error_out(e1), .busy_out(b1));
    sig_rx #(.MESSAGE_WIDTH(1), .CYCLES_PER_BIT(1)) dut2 (
        .clk_in(clk), .rst_in(rst_n), .data_in(d2), .status_in(st2),
        .msg_out(msg2), .msg_valid_out(v2), .error_out(e2), .busy_out(b2));

    always #5 clk = ~clk;

    task automatic chk(string name, int j, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at edge %0d: got %0h expected %0h", name, j, edge_no, act, exp);
        end
    endtask

    // Single compare process: every edge, all instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            for (int j = 0; j < 3; j++) begin
                if (a_valid[j] === 1'b1) begin
                    valid_cnt[j]++;
                    valid_edge[j] = edge_no;
                end
                if (a_err[j] === 1'b1) err_cnt[j]++;
                if (check_en) begin
                    chk("msg",   j, 32'(a_msg[j]),   32'(e_msg[j]));
                    chk("valid", j, 32'(a_valid[j]), 32'(e_valid[j]));
                    chk("error", j, 32'(a_err[j]),   32'(e_err[j]));
                    chk("busy",  j, 32'(a_busy[j]),  32'(e_busy[j]));
                end
            end
        end
    end

    task automatic set_in(int j, logic s, logic d);
        case (j)
            0: begin st0 = s; d0 = d; end
            1: begin st1 = s; d1 = d; end
            default: begin st2 = s; d2 = d; end
        endcase
    endtask

    // Advance to the next negedge with every instance idle by default.
    task automatic begin_cycle();
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            e_valid[j] = 1'b0;
            e_err[j]   = 1'b0;
            e_busy[j]  = 1'b0;
            e_msg[j]   = held_msg[j];
            set_in(j, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    // One frame on instance j: L cycles with status high, then G low cycles.
    task automatic send_frame(int j, logic [15:0] word, int L, int G, bit inv_noise);
        int w, c, mid, s, k;
        logic b, d;
        logic [15:0] mask;
        w    = W_OF[j];
        c    = CPB_OF[j];
        mid  = (c - 1) / 2;
        s    = (w - 1) * c + mid;
        mask = 16'((32'h1 << w) - 1);
        for (int i = 0; i < L + G; i++) begin
            begin_cycle();
            if (i == 0) e0_edge[j] = edge_no + 1;
            if (i < L) begin
                k = i / c;
                if (k < w) begin
                    b = word[w - 1 - k];
                    if (i % c == mid) d = b;
                    else d = inv_noise ? ~b : 1'($urandom_range(0, 1));
                end else begin
                    d = 1'($urandom_range(0, 1));
                end
                set_in(j, 1'b1, d);
                e_busy[j] = 1'b1;
            end
            if (L > s && i == s) begin
                e_valid[j]  = 1'b1;
                held_msg[j] = word & mask;
            end
            if (L <= s && i == L) e_err[j] = 1'b1;
            e_msg[j] = held_msg[j];
        end
    endtask

    initial begin
        int j, L, G;
        rst_n = 1'b0;
        {st0, st1, st2, d0, d1, d2} = '0;
        for (int i = 0; i < 3; i++) begin
            held_msg[i] = '0; e_msg[i] = '0;
            e_valid[i] = 1'b0; e_err[i] = 1'b0; e_busy[i] = 1'b0;
            e0_edge[i] = 0; valid_edge[i] = 0; valid_cnt[i] = 0; err_cnt[i] = 0;
        end
        @(posedge clk); #2;
        chk("reset_msg", 0, 32'(msg0), 32'h0);
        chk("reset_busy", 1, 32'(b1), 32'h0);
        chk("reset_valid", 2, 32'(v2), 32'h0);
        begin_cycle();
        rst_n = 1'b1;
        check_en = 1'b1;
        begin_cycle();

        // Truncated frame after 9 bits: error, msg stays 0, no valid.
        send_frame(0, 16'hBEEF, 9, 2, 1'b0);
        chk("trunc_msg", 0, 32'(msg0), 32'h0);
        chk("trunc_errcnt", 0, 32'(err_cnt[0]), 32'd1);
        chk("trunc_validcnt", 0, 32'(valid_cnt[0]), 32'd0);

        // Basic 16-bit frame, 1 cycle per bit.
        send_frame(0, 16'hBEEF, 16, 2, 1'b0);
        chk("beef_msg", 0, 32'(msg0), 32'hBEEF);
        chk("beef_model", 0, 32'(e_msg[0]), 32'hBEEF);
        chk("beef_latency", 0, 32'(valid_edge[0] - e0_edge[0]), 32'd15);
        chk("beef_validcnt", 0, 32'(valid_cnt[0]), 32'd1);

        // Back-to-back frames with one low cycle, second one over-long by 5.
        send_frame(0, 16'hA5A5, 16, 1, 1'b0);
        chk("b2b_first", 0, 32'(msg0), 32'hA5A5);
        send_frame(0, 16'h0F0F, 21, 2, 1'b0);
        chk("b2b_second", 0, 32'(msg0), 32'h0F0F);
        chk("b2b_validcnt", 0, 32'(valid_cnt[0]), 32'd3);
        chk("b2b_errcnt", 0, 32'(err_cnt[0]), 32'd1);

        // Asynchronous reset after 7 bits of a frame.
        send_frame(0, 16'h5555, 7, 0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_msg", 0, 32'(msg0), 32'h0);
        chk("midrst_busy", 0, 32'(b0), 32'h0);
        chk("midrst_valid", 0, 32'(v0), 32'h0);
        chk("midrst_error", 0, 32'(e0), 32'h0);
        for (int i = 0; i < 3; i++) held_msg[i] = '0;
        begin_cycle();
        begin_cycle();
        begin_cycle();
        rst_n = 1'b1;
        send_frame(0, 16'hC3C3, 16, 2, 1'b0);
        chk("postrst_msg", 0, 32'(msg0), 32'hC3C3);
        chk("postrst_validcnt", 0, 32'(valid_cnt[0]), 32'd4);
        chk("postrst_errcnt", 0, 32'(err_cnt[0]), 32'd1);

        // 4 cycles per bit with inverted data off the sample point.
        send_frame(1, 16'h1234, 64, 2, 1'b1);
        chk("cpb4_msg", 1, 32'(msg1), 32'h1234);
        chk("cpb4_latency", 1, 32'(valid_edge[1] - e0_edge[1]), 32'd61);

        // Single-bit frames.
        send_frame(2, 16'h0001, 1, 1, 1'b0);
        chk("w1_one", 2, 32'(msg2), 32'h1);
        chk("w1_latency", 2, 32'(valid_edge[2] - e0_edge[2]), 32'd0);
        send_frame(2, 16'h0000, 1, 1, 1'b0);
        chk("w1_zero", 2, 32'(msg2), 32'h0);
        chk("w1_validcnt", 2, 32'(valid_cnt[2]), 32'd2);

        // Random frames of random length across all instances.
        for (int n = 0; n < 80; n++) begin
            j = $urandom_range(0, 2);
            L = 1 + $urandom_range(0, W_OF[j] * CPB_OF[j] + 5);
            G = 1 + $urandom_range(0, 2);
            send_frame(j, 16'($urandom), L, G, 1'($urandom_range(0, 1)));
        end

        begin_cycle();
        begin_cycle();
        @(posedge clk); #2;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sig_rx.md
Name: sig_rx

Overview:
- Serial receiver that sits directly downstream of sig_gen and consumes its data_out/status_out pair.
- Recovers the MSB-first framed bit stream into a parallel MESSAGE_WIDTH word.
- Presents the word with a one-cycle valid strobe and flags truncated frames.
- Used for loopback checking of the transmitter and as the capture stage in the pset3 serial link.

Parameters:
- MESSAGE_WIDTH, 16: bits per frame; legal range 1..64.
- CYCLES_PER_BIT, 1: clock cycles each bit is held on data_in; legal range 1..255.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  asynchronous, active-low reset.
- data_in  input  1  serial data from the transmitter's data_out.
- status_in  input  1  frame-active from the transmitter's status_out; high for the whole frame.
- msg_out  output  MESSAGE_WIDTH  last successfully received word; MSB is the first bit received.
- msg_valid_out  output  1  one-cycle pulse when msg_out updates.
- error_out  output  1  one-cycle pulse on a truncated frame.
- busy_out  output  1  high while in RECEIVE or WAIT_IDLE.

Behaviour:
- Reset (rst_in low, asynchronous assert, synchronous release on clk_in rising edge):
  - State = IDLE.
  - msg_out = 0, msg_valid_out = 0, error_out = 0, busy_out = 0.
  - Shift register, bit counter and cycle counter = 0.
- All inputs are sampled on the clk_in rising edge. No input synchronizers; inputs are same-clock-domain.
- Frame timing, all counted from edge E0:
  - E0 = the first edge at which status_in is sampled high while in IDLE.
  - Bit k occupies edges E0 + k*CYCLES_PER_BIT through E0 + (k+1)*CYCLES_PER_BIT - 1.
  - Bit k is sampled at edge E0 + k*CYCLES_PER_BIT + (CYCLES_PER_BIT-1)/2, using integer division (mid-bit).
  - When CYCLES_PER_BIT = 1, bit 0 is sampled at E0 itself. IDLE must sample data_in on the same edge it detects status_in.
- Sampled bits shift in from the LSB side, so after MESSAGE_WIDTH samples the first bit sits in the MSB.
- States:
  - IDLE: busy_out = 0. status_in high -> RECEIVE; cycle counter starts at 0 on E0; sampling rule above applies.
  - RECEIVE:
    - Cycle counter wraps at CYCLES_PER_BIT-1 and increments the bit counter.
    - On the edge sampling bit MESSAGE_WIDTH-1: msg_out <= completed word; msg_valid_out high in the following cycle only; -> WAIT_IDLE.
    - status_in sampled low on any edge before the final sample edge: error_out high for the following cycle only; msg_out unchanged; partial data discarded; -> IDLE.
  - WAIT_IDLE: stay while status_in is high; status_in low -> IDLE.
    - Over-long frames and the remainder of the final bit period are ignored, with no error.
    - status_in falling after the final sample edge but before the final bit period ends is legal.
- A new frame requires status_in to be sampled low for at least one edge between frames. A one-cycle gap is sufficient for back-to-back frames.
- msg_valid_out and error_out never assert in the same cycle. Neither stays high for more than one cycle.
- data_in is ignored except on sample edges.
- Reset mid-frame: everything returns to reset values immediately, with no pulse.
  - If status_in is still high when reset releases, the block starts a frame on the first edge after release. The transmitter is expected to be reset together with the receiver.
- Counter widths: bit counter $clog2(MESSAGE_WIDTH+1); cycle counter $clog2(CYCLES_PER_BIT+1). No overflow is possible within legal ranges.

Test Plan:
1. MESSAGE_WIDTH=16, CYCLES_PER_BIT=1, drive 16'hBEEF MSB first with status_in high for 16 cycles -> msg_valid_out high exactly 1 cycle, 16 cycles after E0; msg_out = 16'hBEEF; error_out stays 0; busy_out high from cycle 1 through the cycle status_in falls.
2. CYCLES_PER_BIT=4, send 16'h1234 with each bit held 4 cycles and data_in forced to the inverted value on non-sample cycles (counter values 0, 2, 3) -> msg_out = 16'h1234 after 64 cycles; valid pulse 62 cycles after E0.
3. Truncated frame: CYCLES_PER_BIT=1, send 16'hBEEF and drop status_in after 9 bits -> error_out 1 cycle; msg_out keeps its prior value (0 after reset); no valid pulse.
4. Back-to-back: 16'hA5A5, one low cycle, then 16'h0F0F -> two valid pulses with msg_out = 16'hA5A5 then 16'h0F0F. Also hold status_in high 5 extra cycles after a frame -> no second pulse, no error.
5. Reset mid-frame: assert rst_in low asynchronously (between edges) after 7 bits of a frame -> outputs zero immediately. Release with status_in low, then send 16'hC3C3 -> msg_out = 16'hC3C3 with a single valid pulse.
6. Edge widths: MESSAGE_WIDTH=1, CYCLES_PER_BIT=1, single-bit frames 1 then 0 -> msg_out = 1 then 0, one valid pulse each, 1 cycle after E0.
